// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_tx
//  Purpose  : Serialises a frame of NUM_LEDS 24-bit GRB pixels from a
//             registered-output pixel ROM onto a WS2812 data line, then
//             holds the line low for the latch period.
//  Revision : 1.0 - initial release
//
//  Ports
//    i_clk    : single clock, all state on its rising edge
//    i_rst_n  : asynchronous active-low reset
//    i_start  : frame request, sampled only while idle
//    o_addr   : pixel ROM read address (holds between reads)
//    o_ren    : pixel ROM read enable, one-cycle pulses
//    i_data   : pixel ROM read data, GRB with G in [23:16]
//    o_dout   : WS2812 serial data line
//    o_busy   : high whenever a frame (or its latch period) is in progress
//    o_done   : one-cycle pulse in the last latch cycle
//
//  Build option
//    WS2812_AUTO_REFRESH_EN : when defined, the latch period is followed
//                             directly by a new frame fetch (continuous
//                             refresh after the first i_start).
// ============================================================================
module ws2812_tx #(
  parameter int NUM_LEDS   = 20,
  parameter int ADDR_LINES = 8,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 63,
  parameter int TRESET     = 3000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic [ADDR_LINES-1:0] o_addr,
  output logic                  o_ren,
  input  logic [23:0]           i_data,
  output logic                  o_dout,
  output logic                  o_busy,
  output logic                  o_done
);

  // One phase counter serves both the bit timing and the latch period.
  localparam int PH_MAX = (TRESET > TBIT) ? TRESET : TBIT;
  localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
  localparam int PIX_W  = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;

  localparam logic [PH_W-1:0]  BIT_LAST   = PH_W'(TBIT - 1);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(TRESET - 1);
  localparam logic [PH_W-1:0]  T0H_C      = PH_W'(T0H);
  localparam logic [PH_W-1:0]  T1H_C      = PH_W'(T1H);
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PH_W-1:0]         phase;
  logic [4:0]              bit_idx;
  logic [PIX_W-1:0]        pixel;
  logic [23:0]             shift;
  logic [23:0]             shadow;
  logic [ADDR_LINES-1:0]   addr;

  logic                    bit_end;
  logic                    last_bit;
  logic                    last_pix;
  logic                    latch_end;
  logic [PH_W-1:0]         high_time;

  assign bit_end   = (phase == BIT_LAST);
  assign last_bit  = (bit_idx == 5'd0);
  assign last_pix  = (pixel == PIX_LAST);
  assign latch_end = (phase == LATCH_LAST);
  assign high_time = shift[23] ? T1H_C : T0H_C;
  assign o_addr    = addr;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs; outputs decode registered state only, so the
  // asynchronous reset forces them low immediately.
  always_comb begin
    state_nxt = state;
    o_ren     = 1'b0;
    o_dout    = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = FETCH;
      end
      FETCH: begin
        o_ren     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = SEND;
      end
      SEND: begin
        o_dout = (phase < high_time);
        // Prefetch the next pixel at the start of the current pixel's last
        // bit so the shadow register is full well before it is needed.
        o_ren  = last_bit && (phase == '0) && !last_pix;
        if (bit_end && last_bit && last_pix) state_nxt = LATCH;
      end
      LATCH: begin
        if (latch_end) begin
          o_done = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
          state_nxt = FETCH;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: counters, shift/shadow registers, ROM address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase   <= '0;
      bit_idx <= '0;
      pixel   <= '0;
      shift   <= '0;
      shadow  <= '0;
      addr    <= '0;
    end else begin
      // Every frame restarts from ROM address 0.
      if (state_nxt == FETCH) addr <= '0;

      case (state)
        WAIT: begin
          // ROM data is only valid in this cycle (read issued in FETCH).
          shift   <= i_data;
          phase   <= '0;
          bit_idx <= 5'd23;
          pixel   <= '0;
        end
        SEND: begin
          // Prefetched data is valid the cycle after the prefetch pulse.
          if (last_bit && (phase == PH_W'(1)) && !last_pix) shadow <= i_data;
          // Present the next address one cycle ahead of the prefetch pulse.
          if ((bit_idx == 5'd1) && bit_end && !last_pix)
            addr <= ADDR_LINES'(pixel) + ADDR_LINES'(1);
          if (bit_end) begin
            phase <= '0;
            if (last_bit) begin
              bit_idx <= 5'd23;
              shift   <= shadow;
              if (!last_pix) pixel <= pixel + PIX_W'(1);
            end else begin
              bit_idx <= bit_idx - 5'd1;
              shift   <= {shift[22:0], 1'b0};
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        LATCH: begin
          phase <= latch_end ? '0 : phase + PH_W'(1);
        end
        default: begin
          phase <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ws2812_tx
//  Purpose  : Self-checking bench for ws2812_tx. Frame vectors are applied
//             from a table; expected bit values and ROM addresses are queued
//             when a frame is requested and consumed as the line is decoded.
//             Define WS2812_AUTO_REFRESH_EN to exercise continuous refresh.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_tx;

  localparam int NUM_LEDS   = 4;
  localparam int ADDR_LINES = 4;
  localparam int T0H        = 3;
  localparam int T1H        = 6;
  localparam int TBIT       = 9;
  localparam int TRESET     = 40;
  localparam int PERIOD     = NUM_LEDS * 24 * TBIT + TRESET + 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_LINES-1:0] addr;
  logic                  ren;
  logic [23:0]           rdata = '0;
  logic                  dout;
  logic                  busy;
  logic                  done;

  ws2812_tx #(
    .NUM_LEDS  (NUM_LEDS),
    .ADDR_LINES(ADDR_LINES),
    .T0H       (T0H),
    .T1H       (T1H),
    .TBIT      (TBIT),
    .TRESET    (TRESET)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .o_addr (addr),
    .o_ren  (ren),
    .i_data (rdata),
    .o_dout (dout),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel ROM with registered output; the bus floats (modelled as 0) in
  // any cycle not preceded by a read enable.
  logic [23:0] rom [2**ADDR_LINES];
  always @(posedge clk) rdata <= ren ? rom[addr] : 24'h0;

  typedef struct {
    logic [23:0] pix0;
    logic [23:0] pix_rest;
    int          exp_ones;
  } vec_t;

  vec_t        vecs [5];
  logic        exp_bits [$];
  int          exp_addr [$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic load_rom(input logic [23:0] p0, input logic [23:0] prest);
    for (int i = 0; i < 2**ADDR_LINES; i++) rom[i] = (i == 0) ? p0 : prest;
  endtask

  task automatic push_expect();
    logic [23:0] px;
    for (int p = 0; p < NUM_LEDS; p++) begin
      px = rom[p];
      exp_addr.push_back(p);
      for (int b = 23; b >= 0; b--) exp_bits.push_back(px[b]);
    end
  endtask

  // Returns at the negedge inside the FETCH cycle.
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge inside FETCH; returns at the negedge inside the
  // last latch cycle.
  task automatic measure_frame(input string tag, output int ones);
    int   hi;
    int   rens;
    int   a;
    bit   ok;
    bit   exp_ren;
    logic e;
    ones = 0;
    rens = 0;
    a = (exp_addr.size() != 0) ? exp_addr.pop_front() : -1;
    check({tag, "_fetch_ren_busy"}, int'({ren, busy}), 3);
    check({tag, "_fetch_addr"}, int'(addr), a);
    if (ren) rens++;
    @(negedge clk);
    check({tag, "_wait_line"}, int'({dout, ren}), 0);
    for (int k = 0; k < NUM_LEDS * 24; k++) begin
      hi = 0;
      ok = 1'b1;
      for (int c = 0; c < TBIT; c++) begin
        @(negedge clk);
        if (dout) begin
          if (hi != c) ok = 1'b0;
          hi++;
        end
        if (!busy || done) ok = 1'b0;
        exp_ren = (k % 24 == 23) && (c == 0) && (k / 24 < NUM_LEDS - 1);
        if (ren !== exp_ren) ok = 1'b0;
        if (ren) begin
          rens++;
          a = (exp_addr.size() != 0) ? exp_addr.pop_front() : -1;
          if (int'(addr) != a) ok = 1'b0;
        end
      end
      e = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'bx;
      check($sformatf("%s_bit%0d_high", tag, k), ok ? hi : -1, (e === 1'b1) ? T1H : T0H);
      if (hi == T1H) ones++;
    end
    check({tag, "_ren_count"}, rens, NUM_LEDS);
    ok = 1'b1;
    for (int c = 0; c < TRESET; c++) begin
      @(negedge clk);
      if (dout || ren || !busy) ok = 1'b0;
      if (done !== (c == TRESET - 1)) ok = 1'b0;
    end
    check({tag, "_latch_low_done"}, int'(ok), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    int t0;
    bit ok;

    vecs[0] = '{24'h000F00, 24'h000F00, 16};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 24};
    vecs[2] = '{24'hA5A5A5, 24'h5A5A5A, 48};
    vecs[3] = '{24'h800001, 24'h123456, 29};
    vecs[4] = '{24'h000000, 24'hFFFFFF, 72};

    // Reset state
    @(negedge clk);
    check("reset_outputs", int'({dout, ren, busy, done}), 0);
    check("reset_addr", int'(addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outputs", int'({dout, ren, busy, done}), 0);

`ifdef WS2812_AUTO_REFRESH_EN
    load_rom(vecs[0].pix0, vecs[0].pix_rest);
    push_expect();
    start_frame();
    measure_frame("auto0", ones);
    check("auto0_ones", ones, vecs[0].exp_ones);
    t0 = cyc;
    for (int f = 1; f < 3; f++) begin
      @(negedge clk);
      push_expect();
      measure_frame($sformatf("auto%0d", f), ones);
      check($sformatf("auto%0d_period", f), cyc - t0, PERIOD);
      check($sformatf("auto%0d_ones", f), ones, vecs[0].exp_ones);
      t0 = cyc;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("auto_reset_stop", int'({dout, ren, busy, done}), 0);
    rst_n = 1'b1;
`else
    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      load_rom(vecs[v].pix0, vecs[v].pix_rest);
      push_expect();
      start_frame();
      measure_frame($sformatf("vec%0d", v), ones);
      check($sformatf("vec%0d_ones", v), ones, vecs[v].exp_ones);
      @(negedge clk);
      check($sformatf("vec%0d_busy_fall", v), int'({busy, done}), 0);
      repeat (2) @(negedge clk);
    end

    // i_start held high across a whole frame: one frame, then a new one only
    // once IDLE has been reached.
    load_rom(24'h00FF00, 24'hF0F0F0);
    push_expect();
    start_frame();
    start = 1'b1;
    measure_frame("held0", ones);
    @(negedge clk);
    check("held_idle_reached", int'({busy, done}), 0);
    @(negedge clk);
    start = 1'b0;
    push_expect();
    measure_frame("held1", ones);
    check("held1_ones", ones, 8 + 3 * 12);
    @(negedge clk);
    check("held1_busy_fall", int'({busy, done}), 0);

    // Asynchronous reset in the middle of pixel 2
    load_rom(24'h0F0F0F, 24'h3C3C3C);
    exp_bits.delete();
    exp_addr.delete();
    start_frame();
    repeat (2 + 60 * TBIT) @(negedge clk);
    check("abort_line_high", int'({dout, busy}), 3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_clear", int'({dout, ren, busy, done}), 0);
    check("abort_addr", int'(addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (TRESET + 200) begin
      @(negedge clk);
      if (done || busy || ren || dout) ok = 1'b0;
    end
    check("abort_no_done", int'(ok), 1);
    push_expect();
    start_frame();
    measure_frame("resend", ones);
    check("resend_ones", ones, 12 + 3 * 12);
    @(negedge clk);
    check("resend_busy_fall", int'({busy, done}), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
